// File: rtl/fpwm_pkg.sv
// Shared frame-layout definitions for the fpwm SPI link.
// Both the SPI initiator and the fpwm receiver import this package, so the
// byte order of the configuration frame is defined in exactly one place.
//   FRAME_BYTES / FRAME_BITS : frame size
//   BYTE_*                   : transmit order of each byte (0 is sent first)
//   spi_state_e              : initiator sequencing states
//   pack_frame()             : builds the MSB-first 40-bit frame image
package fpwm_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_BITS  = 8 * FRAME_BYTES;

  localparam int BYTE_P0  = 0;
  localparam int BYTE_P1  = 1;
  localparam int BYTE_N0  = 2;
  localparam int BYTE_N1  = 3;
  localparam int BYTE_CFG = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_LAG,
    ST_GAP
  } spi_state_e;

  // Byte 0 lands in the top 8 bits so that shifting out bit FRAME_BITS-1
  // first yields the wire order p0, p1, n0, n1, cfg.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [15:0] pos,
    input logic [15:0] neg,
    input logic [7:0]  cfg
  );
    logic [7:0]            bytes [FRAME_BYTES];
    logic [FRAME_BITS-1:0] frame;
    bytes[BYTE_P0]  = pos[15:8];
    bytes[BYTE_P1]  = pos[7:0];
    bytes[BYTE_N0]  = neg[15:8];
    bytes[BYTE_N1]  = neg[7:0];
    bytes[BYTE_CFG] = cfg;
    frame = '0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      frame[FRAME_BITS-1-8*i -: 8] = bytes[i];
    end
    return frame;
  endfunction

endpackage

// File: rtl/fpwm_spi_master.sv
// SPI mode-0 initiator that sends one fpwm configuration frame
// (positive width, negative width, config byte; 40 bits MSB first) per
// slave-select assertion. SCK half-period is CLK_DIV system clocks.
// Ports:
//   i_Clk    system clock
//   i_Reset  asynchronous active-high reset
//   i_Start  request a frame (only honoured while idle)
//   i_Pos    positive width, sent as [15:8] then [7:0]
//   i_Neg    negative width, sent as [15:8] then [7:0]
//   i_Cfg    config byte, sent last
//   o_MOSI   serial data, changes on SCK falling edge
//   o_SCK    serial clock, idle low
//   o_SS     slave select, active low
//   o_Busy   high from frame start until the post-frame gap ends
//   o_Done   one-cycle pulse coincident with SS returning high
module fpwm_spi_master
  import fpwm_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [15:0] i_Pos,
  input  logic [15:0] i_Neg,
  input  logic [7:0]  i_Cfg,
  output logic        o_MOSI,
  output logic        o_SCK,
  output logic        o_SS,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam logic [7:0] PRE_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

  spi_state_e            state, state_nxt;
  logic [7:0]            pre_cnt, pre_cnt_nxt;
  logic [5:0]            bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  pre_last;
  logic                  load;
  logic                  shift;
  logic                  in_frame;

  assign pre_last = (pre_cnt == PRE_LAST);
  assign load     = (state == ST_IDLE) && i_Start;
  // Shift only when moving HIGH->LOW, so the new bit appears with the
  // falling SCK edge and the final bit is held through LAG.
  assign shift    = (state == ST_HIGH) && pre_last && (bit_cnt != BIT_LAST);
  assign in_frame = (state == ST_LEAD) || (state == ST_HIGH) ||
                    (state == ST_LOW)  || (state == ST_LAG);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= ST_IDLE;
      pre_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= pre_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    pre_cnt_nxt = '0;
    if (state != ST_IDLE && !pre_last) begin
      pre_cnt_nxt = pre_cnt + 8'd1;
    end
    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          state_nxt   = ST_LEAD;
          bit_cnt_nxt = '0;
        end
      end
      ST_LEAD: if (pre_last) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (pre_last) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_LAG;
          end else begin
            state_nxt   = ST_LOW;
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      ST_LOW:  if (pre_last) state_nxt = ST_HIGH;
      ST_LAG:  if (pre_last) state_nxt = ST_GAP;
      ST_GAP:  if (pre_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame data register carries no reset: it is always reloaded before use.
  always_ff @(posedge i_Clk) begin
    if (load) begin
      shreg <= pack_frame(i_Pos, i_Neg, i_Cfg);
    end else if (shift) begin
      shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Output stage: pins are decoded from the current state and registered,
  // which puts every pin one cycle behind the state it represents.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_SS   <= 1'b1;
      o_SCK  <= 1'b0;
      o_MOSI <= 1'b0;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
    end else begin
      o_SS   <= !in_frame;
      o_SCK  <= (state == ST_HIGH);
      o_MOSI <= in_frame ? shreg[FRAME_BITS-1] : 1'b0;
      o_Busy <= (state != ST_IDLE);
      o_Done <= (state == ST_GAP) && (pre_cnt == 8'd0);
    end
  end

endmodule

// File: tb/tb_fpwm_spi_master.sv
module tb_fpwm_spi_master;

  localparam int D0 = 10;
  localparam int D1 = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       start;
  logic [1:0][15:0] pos;
  logic [1:0][15:0] neg;
  logic [1:0][7:0]  cfg;
  logic [1:0]       mosi, sck, ss, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpwm_spi_master #(.CLK_DIV(D0)) dut10 (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start[0]),
    .i_Pos(pos[0]), .i_Neg(neg[0]), .i_Cfg(cfg[0]),
    .o_MOSI(mosi[0]), .o_SCK(sck[0]), .o_SS(ss[0]),
    .o_Busy(busy[0]), .o_Done(done[0])
  );

  fpwm_spi_master #(.CLK_DIV(D1)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start[1]),
    .i_Pos(pos[1]), .i_Neg(neg[1]), .i_Cfg(cfg[1]),
    .o_MOSI(mosi[1]), .o_SCK(sck[1]), .o_SS(ss[1]),
    .o_Busy(busy[1]), .o_Done(done[1])
  );

  function automatic int dv(input int m);
    return (m == 0) ? D0 : D1;
  endfunction

  // Reference: the five bytes in wire order, accumulated as a base-256 number.
  function automatic logic [39:0] ref_frame(input logic [15:0] p, input logic [15:0] n,
                                            input logic [7:0] c);
    int unsigned b [5];
    logic [39:0] acc;
    b[0] = p / 256; b[1] = p % 256; b[2] = n / 256; b[3] = n % 256; b[4] = c;
    acc = 40'd0;
    for (int i = 0; i < 5; i++) acc = acc * 256 + 40'(b[i]);
    return acc;
  endfunction

  // SPI slave monitor, sampled on the falling system-clock edge
  int          cyc = 0;
  logic [1:0]  p_ss = 2'b11, p_sck = 2'b00, p_mosi = 2'b00, p_busy = 2'b00;
  logic [39:0] cap [2];
  logic [39:0] cap_last [2];
  int rises [2], rises_last [2], fall_cyc [2], rise_ss_cyc [2], low_len [2];
  int gap_len [2], fall_gap [2], frames [2], falls [2], done_cnt [2];
  int done_at_rise [2], done_cyc [2], busy_fall_cyc [2], last_chg [2];
  int last_rise [2], setup_viol [2], hold_viol [2], stray [2];

  initial begin
    for (int m = 0; m < 2; m++) begin
      cap[m] = '0; cap_last[m] = '0; rises[m] = 0; rises_last[m] = 0;
      fall_cyc[m] = 0; rise_ss_cyc[m] = 0; low_len[m] = 0; gap_len[m] = 0;
      fall_gap[m] = 0; frames[m] = 0; falls[m] = 0; done_cnt[m] = 0;
      done_at_rise[m] = 0; done_cyc[m] = 0; busy_fall_cyc[m] = 0;
      last_chg[m] = 0; last_rise[m] = -1000000; setup_viol[m] = 0;
      hold_viol[m] = 0; stray[m] = 0;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int m = 0; m < 2; m++) begin
      p_ss[m]   <= ss[m];
      p_sck[m]  <= sck[m];
      p_mosi[m] <= mosi[m];
      p_busy[m] <= busy[m];
      if (!ss[m] && p_ss[m]) begin
        falls[m]     <= falls[m] + 1;
        fall_cyc[m]  <= cyc;
        gap_len[m]   <= cyc - rise_ss_cyc[m];
        fall_gap[m]  <= cyc - fall_cyc[m];
        cap[m]       <= '0;
        rises[m]     <= 0;
        last_chg[m]  <= cyc;
        last_rise[m] <= -1000000;
      end else if (!ss[m] && !p_ss[m]) begin
        if (sck[m] && !p_sck[m]) begin
          cap[m]       <= {cap[m][38:0], mosi[m]};
          rises[m]     <= rises[m] + 1;
          last_rise[m] <= cyc;
          if (cyc - last_chg[m] < dv(m)) setup_viol[m] <= setup_viol[m] + 1;
        end
        if (mosi[m] != p_mosi[m]) begin
          last_chg[m] <= cyc;
          if (cyc - last_rise[m] < dv(m)) hold_viol[m] <= hold_viol[m] + 1;
        end
      end
      if (ss[m] && !p_ss[m]) begin
        frames[m]      <= frames[m] + 1;
        rise_ss_cyc[m] <= cyc;
        low_len[m]     <= cyc - fall_cyc[m];
        cap_last[m]    <= cap[m];
        rises_last[m]  <= rises[m];
        if (done[m]) done_at_rise[m] <= done_at_rise[m] + 1;
      end
      if (sck[m] && ss[m]) stray[m] <= stray[m] + 1;
      if (done[m]) begin
        done_cnt[m] <= done_cnt[m] + 1;
        done_cyc[m] <= cyc;
      end
      if (!busy[m] && p_busy[m]) busy_fall_cyc[m] <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int m, input int target, input int limit, input string tag);
    int g = 0;
    while (frames[m] < target && g < limit) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_timeout"}, 64'(frames[m] >= target), 64'd1);
  endtask

  task automatic send(input int m, input logic [15:0] p, input logic [15:0] n,
                      input logic [7:0] c, input string tag);
    int f0, dc0, dr0;
    logic [39:0] exp;
    exp = ref_frame(p, n, c);
    @(negedge clk);
    f0 = frames[m]; dc0 = done_cnt[m]; dr0 = done_at_rise[m];
    pos[m] = p; neg[m] = n; cfg[m] = c; start[m] = 1'b1;
    @(negedge clk);
    start[m] = 1'b0;
    pos[m] = 16'($urandom); neg[m] = 16'($urandom); cfg[m] = 8'($urandom);
    wait_frames(m, f0 + 1, 90 * dv(m) + 20, tag);
    repeat (dv(m) + 4) @(negedge clk);
    chk({tag, "_bytes"}, 64'(cap_last[m]), 64'(exp));
    chk({tag, "_rises"}, 64'(rises_last[m]), 64'd40);
    chk({tag, "_ss_low"}, 64'(low_len[m]), 64'(81 * dv(m)));
    chk({tag, "_done_cnt"}, 64'(done_cnt[m] - dc0), 64'd1);
    chk({tag, "_done_at_ss"}, 64'(done_at_rise[m] - dr0), 64'd1);
    chk({tag, "_busy_tail"}, 64'(busy_fall_cyc[m] - done_cyc[m]), 64'(dv(m)));
    chk({tag, "_setup"}, 64'(setup_viol[m]), 64'd0);
    chk({tag, "_hold"}, 64'(hold_viol[m]), 64'd0);
    chk({tag, "_stray_sck"}, 64'(stray[m]), 64'd0);
  endtask

  initial begin
    int f, fl, dc, g;
    logic [15:0] rp, rn;
    logic [7:0]  rc;
    rst = 1'b1;
    start = '0; pos = '0; neg = '0; cfg = '0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++)
      chk("reset_outputs", 64'({ss[m], sck[m], mosi[m], busy[m], done[m]}), 64'b10000);
    rst = 1'b0;

    // idle with no Start
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("idle", 64'({ss, sck, mosi, busy, done}), 64'({2'b11, 2'b00, 2'b00, 2'b00, 2'b00}));
    end

    // directed frames
    send(0, 16'h1234, 16'h5678, 8'h11, "div10_basic");
    send(1, 16'hFFFF, 16'h0000, 8'hA5, "div2_edge");

    // random frames on both prescaler settings
    for (int i = 0; i < 3; i++) begin
      send(0, 16'($urandom), 16'($urandom), 8'($urandom), "div10_rand");
      send(1, 16'($urandom), 16'($urandom), 8'($urandom), "div2_rand");
    end

    // Start held high: back-to-back frames
    rp = 16'($urandom); rn = 16'($urandom); rc = 8'($urandom);
    @(negedge clk);
    f = frames[0];
    pos[0] = rp; neg[0] = rn; cfg[0] = rc; start[0] = 1'b1;
    wait_frames(0, f + 1, 900, "held_first");
    repeat (D0 + 5) @(negedge clk);
    start[0] = 1'b0;
    chk("held_start_to_start", 64'(fall_gap[0]), 64'(82 * D0 + 1));
    chk("held_ss_gap_min", 64'(gap_len[0] >= D0), 64'd1);
    chk("held_first_bytes", 64'(cap_last[0]), 64'(ref_frame(rp, rn, rc)));
    wait_frames(0, f + 2, 900, "held_second");
    chk("held_second_bytes", 64'(cap_last[0]), 64'(ref_frame(rp, rn, rc)));
    repeat (900) @(negedge clk);
    chk("held_no_third", 64'(frames[0] - f), 64'd2);

    // second Start mid-frame is ignored
    rp = 16'($urandom); rn = 16'($urandom); rc = 8'($urandom);
    @(negedge clk);
    f = frames[0]; fl = falls[0];
    pos[0] = rp; neg[0] = rn; cfg[0] = rc; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (300) @(negedge clk);
    pos[0] = ~rp; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_frames(0, f + 1, 900, "mid_start");
    repeat (900) @(negedge clk);
    chk("mid_start_frames", 64'(frames[0] - f), 64'd1);
    chk("mid_start_falls", 64'(falls[0] - fl), 64'd1);
    chk("mid_start_bytes", 64'(cap_last[0]), 64'(ref_frame(rp, rn, rc)));

    // reset in the middle of a frame
    @(negedge clk);
    dc = done_cnt[0];
    pos[0] = 16'($urandom); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    g = 0;
    while (rises[0] < 20 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reach_rise20", 64'(rises[0] >= 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", 64'({ss[0], sck[0], mosi[0], busy[0], done[0]}), 64'b10000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt[0] - dc), 64'd0);
    chk("abort_idle", 64'({ss[0], busy[0]}), 64'b10);
    send(0, 16'($urandom), 16'($urandom), 8'($urandom), "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
